ram_port_arbiter: RTL

Two-requester round-robin arbiter for the 64x8 single-port synchronous RAM (one write port, one read address, registered `data_out`, one access per clock). It gives each requester a simple req/gnt interface with write data, read-data return and burst fairness, and drives the RAM's `we`, `write_addr`, `read_addr` and `data_in` directly. It sits between the RAM instance and two client blocks, for example a DMA engine and a CPU-side port.

---
 rtl/ram_port_arbiter_if.sv | 46 ++++
 rtl/ram_port_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_port_arbiter.
// slave = arbiter side, master = clients plus RAM.
interface ram_port_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic          ram_we;
    logic [AW-1:0] ram_write_addr;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_data_out,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_we, ram_write_addr, ram_read_addr, ram_data_in
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_data_out,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_we, ram_write_addr, ram_read_addr, ram_data_in
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One issue slot per cycle; owner keeps the slot for up to MAX_BURST grants while contended.
module ram_port_arbiter #(
    parameter int AW        = 6,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);
    localparam int            CW  = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MB  = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic          LAST_A = 1'b0;
    localparam logic          LAST_B = 1'b1;

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last, last_n;
    logic          gnt_a, gnt_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= LAST_B;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

    // Handover grants in the deciding cycle, so a switch of owner costs no bubble.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.a_req && (!bus.b_req || last == LAST_B)) begin
                    gnt_a   = 1'b1;
                    state_n = OWN_A;
                    cnt_n   = ONE;
                end else if (bus.b_req) begin
                    gnt_b   = 1'b1;
                    state_n = OWN_B;
                    cnt_n   = ONE;
                end
            end
            OWN_A: begin
                if (bus.a_req && (cnt < MB || !bus.b_req)) begin
                    gnt_a = 1'b1;
                    if (cnt < MB) cnt_n = cnt + ONE;
                end else if (bus.b_req) begin
                    gnt_b   = 1'b1;
                    state_n = OWN_B;
                    cnt_n   = ONE;
                    last_n  = LAST_A;
                end else begin
                    state_n = IDLE;
                    last_n  = LAST_A;
                end
            end
            OWN_B: begin
                if (bus.b_req && (cnt < MB || !bus.a_req)) begin
                    gnt_b = 1'b1;
                    if (cnt < MB) cnt_n = cnt + ONE;
                end else if (bus.a_req) begin
                    gnt_a   = 1'b1;
                    state_n = OWN_A;
                    cnt_n   = ONE;
                    last_n  = LAST_B;
                end else begin
                    state_n = IDLE;
                    last_n  = LAST_B;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!rst_n) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    always_comb begin
        bus.a_gnt          = gnt_a;
        bus.b_gnt          = gnt_b;
        bus.ram_we         = 1'b0;
        bus.ram_write_addr = '0;
        bus.ram_read_addr  = '0;
        bus.ram_data_in    = '0;
        if (gnt_a) begin
            bus.ram_we         = bus.a_we;
            bus.ram_write_addr = bus.a_addr;
            bus.ram_read_addr  = bus.a_addr;
            bus.ram_data_in    = bus.a_wdata;
        end else if (gnt_b) begin
            bus.ram_we         = bus.b_we;
            bus.ram_write_addr = bus.b_addr;
            bus.ram_read_addr  = bus.b_addr;
            bus.ram_data_in    = bus.b_wdata;
        end
    end

    // RAM data_out is registered, so a read granted now is valid next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
        end else begin
            bus.a_rvalid <= gnt_a & ~bus.a_we;
            bus.b_rvalid <= gnt_b & ~bus.b_we;
        end
    end

    assign bus.a_rdata = bus.ram_data_out;
    assign bus.b_rdata = bus.ram_data_out;
endmodule
